medyan_birimi: RTL and testbench
================================

# medyan_birimi

Streaming 3x3 median unit for the pixel filtering pipeline. Accepts one pixel per cycle while enabled, collects a window of 9 samples, and outputs their median with a one-cycle ready pulse. It keeps a running sorted list of the window, so the result is available one cycle after the 9th sample.

## Interface
- PIXEL_BIT, default 8: pixel width; matches the `PIXEL_BIT` macro in `sabitler.vh`.
- WINDOW, default 9: samples per window; fixed at 9 for this block, with the median at sorted index 4.
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  one clock; reset is synchronous and active-high.
- etkin_i  input  1  sample valid/enable; `sayi_i` is accepted on each rising edge where this is high.
- sayi_i  input  PIXEL_BIT  unsigned pixel sample.
- medyan_o  output  PIXEL_BIT  median of the last completed window; registered.
- hazir_o  output  1  one-cycle pulse: `medyan_o` has just been updated.

## Operation
- State:
  - sorted register array `s[0..8]`, ascending;
  - 4-bit sample count `cnt`, range 0..8;
  - output registers.
- Accept: at an edge with `rst_i=0` and `etkin_i=1`, insert `sayi_i` into the valid entries `s[0..cnt-1]`.
  - Insert position p = the number of valid entries ≤ `sayi_i`, so ties go after equal entries.
  - Entries at p..cnt-1 shift up one; `s[p] <= sayi_i`.
  - All comparisons are unsigned, full width.
- Only entries 0..cnt-1 are meaningful. Stale entries need no clearing.
- If `cnt < 8` before the accept: `cnt <= cnt+1`.
- If `cnt == 8` (the 9th sample): `medyan_o <= s_next[4]`, where `s_next` is the post-insertion array computed combinationally in the same cycle. Also `hazir_o <= 1` and `cnt <= 0`.
- `etkin_i=0`: no state change except `hazir_o <= 0`. Gaps inside a window are allowed; the window resumes with the next accepted sample.
- Windows do not overlap. Each 9 accepted samples produce exactly one result.
- `medyan_o` holds its value until the next window completes.
- Reset: `cnt <= 0`, `medyan_o <= 0`, `hazir_o <= 0`. Any partial window is discarded. Array contents are don't-care.

## Timing
- Latency: the 9th sample is accepted at edge N; `hazir_o=1` and `medyan_o` are valid during the cycle following edge N. `hazir_o` drops at edge N+1.
- No backpressure; the unit accepts a sample on every enabled cycle.
- Sustained throughput is one result per 9 enabled cycles.
- A sample presented while `hazir_o=1` is accepted as sample 1 of the next window.
- Reset asserted mid-window: the partial window is lost and no `hazir_o` pulse is generated for it. The next 9 accepted samples after release form a fresh window.
- Reset has priority over `etkin_i`.
- The single-cycle insert path is one compare per entry plus a shift mux. No multi-cycle paths.

## Test plan
- Basic window:
  - Stimulus: after reset, `etkin_i=1` with 7,7,1,1,1,2,2,9,8 on consecutive cycles, then `etkin_i=0`.
  - Required: exactly one `hazir_o` pulse, in the cycle after the 9th edge, with `medyan_o=2`; `medyan_o` holds 2 afterwards.
- Repeat window:
  - Stimulus: the same sequence, 2 idle cycles, then the same sequence again.
  - Required: two separate single-cycle `hazir_o` pulses, both with `medyan_o=2`, and no pulse during the idle gap.
- Gapped window:
  - Stimulus: 9,8,7,6,5,4,3,2,1 with `etkin_i` deasserted for 1–3 cycles between random samples.
  - Required: `medyan_o=5`, pulse one cycle after the 9th accepted sample only.
- Extremes and ties:
  - Stimulus: nine samples of 255.
  - Required: `medyan_o=255`.
  - Stimulus: 0,255,0,255,0,255,0,255,128.
  - Required: `medyan_o=128`.
- Reset mid-window:
  - Stimulus: 5 samples, `rst_i` high for 1 cycle, then 1..9 ascending.
  - Required: `medyan_o=0` and `hazir_o=0` after reset; a single pulse with `medyan_o=5` after the 9th post-reset sample.
- Back-to-back:
  - Stimulus: 18 consecutive enabled samples: 1..9 followed by 10..18.
  - Required: a pulse with `medyan_o=5`; the 10th sample is accepted during that pulse; then a second pulse 9 cycles later with `medyan_o=14`.

Source files
------------

// File: rtl/medyan_birimi.sv
`default_nettype none
// ============================================================================
// Module   : medyan_birimi
// Purpose  : Streaming 3x3 median unit. Collects non-overlapping windows of
//            nine accepted pixels in an incrementally sorted register array
//            and publishes the median with a single-cycle ready pulse, one
//            cycle after the ninth sample is accepted.
// Revision : 1.0  initial release
// ============================================================================
module medyan_birimi #(
   parameter int PIXEL_BIT = 8,
   parameter int WINDOW    = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 etkin_i,
   input  logic [PIXEL_BIT-1:0] sayi_i,
   output logic [PIXEL_BIT-1:0] medyan_o,
   output logic                 hazir_o
);

   // Count saturates at WINDOW-1; the next accept closes the window.
   localparam logic [3:0] c_last = 4'(WINDOW - 1);
   localparam int         c_mid  = (WINDOW - 1) / 2;

   logic [PIXEL_BIT-1:0] r_s      [WINDOW];
   logic [PIXEL_BIT-1:0] w_s_next [WINDOW];
   logic [WINDOW-1:0]    w_keep;
   logic [3:0]           r_cnt;
   logic [PIXEL_BIT-1:0] r_medyan;
   logic                 r_hazir;

   // An entry stays in place when it is valid and not greater than the new
   // sample. Because the array is sorted, these flags form a contiguous run
   // starting at index 0, and the run length is the insert position.
   for (genvar i = 0; i < WINDOW; i++) begin : g_keep
      localparam logic [3:0] c_idx = 4'(i);
      assign w_keep[i] = (c_idx < r_cnt) && (r_s[i] <= sayi_i);
   end

   // Post-insertion array: entries below the insert position stay, the entry
   // at the insert position takes the sample, entries above it shift up by
   // one. Entries beyond the new valid length are left untouched.
   for (genvar i = 0; i < WINDOW; i++) begin : g_next
      if (i == 0) begin : g_first
         assign w_s_next[i] = w_keep[i] ? r_s[i] : sayi_i;
      end else begin : g_rest
         localparam logic [3:0] c_idx = 4'(i);
         assign w_s_next[i] = (c_idx > r_cnt) ? r_s[i]  :
                              w_keep[i]       ? r_s[i]  :
                              w_keep[i-1]     ? sayi_i  :
                                                r_s[i-1];
      end
   end

   // Sorted window storage; contents need no reset since only the first
   // r_cnt entries are ever consulted.
   always_ff @(posedge clk_i) begin
      if (!rst_i && etkin_i) begin
         r_s <= w_s_next;
      end
   end

   // Sample counter, median register and ready pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt    <= 4'd0;
         r_medyan <= '0;
         r_hazir  <= 1'b0;
      end else begin
         r_hazir <= 1'b0;
         if (etkin_i) begin
            if (r_cnt == c_last) begin
               r_medyan <= w_s_next[c_mid];
               r_hazir  <= 1'b1;
               r_cnt    <= 4'd0;
            end else begin
               r_cnt <= r_cnt + 4'd1;
            end
         end
      end
   end

   assign medyan_o = r_medyan;
   assign hazir_o  = r_hazir;

endmodule
`default_nettype wire

// File: tb/tb_medyan_birimi.sv
`default_nettype none
// ============================================================================
// Module   : tb_medyan_birimi
// Purpose  : Self-checking bench for medyan_birimi: directed window table,
//            hand-written multi-cycle sequences, and a randomized run
//            compared cycle by cycle against a queue-based median model.
// Revision : 1.0  initial release
// ============================================================================
module tb_medyan_birimi;

   logic       clk_i;
   logic       rst_i;
   logic       etkin_i;
   logic [7:0] sayi_i;
   logic [7:0] medyan_o;
   logic       hazir_o;

   int n_pass  = 0;
   int n_total = 0;

   medyan_birimi #(.PIXEL_BIT(8), .WINDOW(9)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .etkin_i (etkin_i),
      .sayi_i  (sayi_i),
      .medyan_o(medyan_o),
      .hazir_o (hazir_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int         mq[$];
   logic       m_hz;
   logic [7:0] m_med;

   function automatic int median9(input int q[$]);
      int a[9];
      int t;
      for (int i = 0; i < 9; i++) a[i] = q[i];
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[4];
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         mq.delete();
         m_hz  = 1'b0;
         m_med = 8'd0;
      end else begin
         m_hz = 1'b0;
         if (etkin_i) begin
            mq.push_back(int'(sayi_i));
            if (mq.size() == 9) begin
               m_med = 8'(median9(mq));
               m_hz  = 1'b1;
               mq.delete();
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      chk("mon_hazir", int'(hazir_o), int'(m_hz));
      chk("mon_medyan", int'(medyan_o), int'(m_med));
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic en, input logic [7:0] x);
      @(posedge clk_i);
      #1;
      etkin_i = en;
      sayi_i  = x;
   endtask

   // Presents nine samples, first sample at index 8; optional idle gaps.
   task automatic feed(input logic [8:0][7:0] s, input bit gaps);
      for (int k = 8; k >= 0; k--) begin
         if (gaps && k < 8 && $urandom_range(0, 1) == 1) begin
            int g = $urandom_range(1, 3);
            for (int m = 0; m < g; m++) drive(1'b0, 8'($urandom));
         end
         drive(1'b1, s[k]);
      end
   endtask

   // Closes a window (the last sample is accepted at this edge) and checks
   // the pulse, then checks the pulse drops and the median holds.
   task automatic close_and_check(input string name, input int exp);
      drive(1'b0, 8'd0);
      chk({name, "_hazir"}, int'(hazir_o), 1);
      chk({name, "_med"}, int'(medyan_o), exp);
      drive(1'b0, 8'd0);
      chk({name, "_drop"}, int'(hazir_o), 0);
      chk({name, "_hold"}, int'(medyan_o), exp);
   endtask

   typedef struct packed {
      logic [8:0][7:0] s;
      logic [7:0]      med;
   } vec_t;

   vec_t vecs[6];

   initial begin
      rst_i   = 1'b1;
      etkin_i = 1'b0;
      sayi_i  = 8'd0;

      vecs[0] = '{s: {8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd8}, med: 8'd2};
      vecs[1] = '{s: {9{8'd255}}, med: 8'd255};
      vecs[2] = '{s: {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128}, med: 8'd128};
      vecs[3] = '{s: {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, med: 8'd5};
      vecs[4] = '{s: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, med: 8'd5};
      vecs[5] = '{s: {8'd30, 8'd10, 8'd20, 8'd10, 8'd30, 8'd20, 8'd40, 8'd0, 8'd20}, med: 8'd20};

      drive(1'b0, 8'd0);
      drive(1'b0, 8'd0);
      rst_i = 1'b0;
      chk("reset_med", int'(medyan_o), 0);
      chk("reset_hazir", int'(hazir_o), 0);

      // Table: contiguous windows.
      for (int v = 0; v < 6; v++) begin
         feed(vecs[v].s, 1'b0);
         close_and_check($sformatf("vec%0d", v), int'(vecs[v].med));
      end

      // Repeat window with a 2-cycle idle gap (monitor watches the gap).
      feed(vecs[0].s, 1'b0);
      close_and_check("rep1", 2);
      feed(vecs[0].s, 1'b0);
      close_and_check("rep2", 2);

      // Gapped window, descending samples.
      feed(vecs[3].s, 1'b1);
      close_and_check("gapped", 5);

      // Reset mid-window after a nonzero median is held.
      for (int k = 0; k < 5; k++) drive(1'b1, 8'(200 + k));
      @(posedge clk_i); #1;
      rst_i = 1'b1; etkin_i = 1'b1; sayi_i = 8'd77;
      @(posedge clk_i); #1;
      rst_i = 1'b0; etkin_i = 1'b0;
      chk("midrst_med", int'(medyan_o), 0);
      chk("midrst_hazir", int'(hazir_o), 0);
      feed(vecs[4].s, 1'b0);
      close_and_check("postrst", 5);

      // Back-to-back: 1..9 then 10..18 with no idle cycle.
      for (int k = 1; k <= 9; k++) drive(1'b1, 8'(k));
      drive(1'b1, 8'd10);
      chk("b2b1_hazir", int'(hazir_o), 1);
      chk("b2b1_med", int'(medyan_o), 5);
      for (int k = 11; k <= 18; k++) begin
         drive(1'b1, 8'(k));
         chk("b2b_nopulse", int'(hazir_o), 0);
      end
      drive(1'b0, 8'd0);
      chk("b2b2_hazir", int'(hazir_o), 1);
      chk("b2b2_med", int'(medyan_o), 14);

      // Randomized traffic with occasional resets; the monitor checks it.
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk_i); #1;
         rst_i   = ($urandom_range(0, 199) == 0);
         etkin_i = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       sayi_i = 8'($urandom_range(0, 3));
            1:       sayi_i = 8'($urandom_range(252, 255));
            default: sayi_i = 8'($urandom);
         endcase
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0; etkin_i = 1'b0;
      drive(1'b0, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
